// File: rtl/alu_cmd_issuer_if.sv
// Channel bundle between the ALU command issuer and its environment.
// Carries the command channel (valid/ready + operands + function code), the
// drive/return signals of the registered arithmetic unit, and the response
// channel (valid/ready + result + status flags + completed-op counter).
//   master : the issuer's view (drives cmd_ready, ALU inputs, response side)
//   slave  : the environment's view (upstream controller, ALU, consumer)
interface alu_cmd_issuer_if #(
  parameter int Data_In_Width = 16,
  parameter int CNT_W         = 8
);
  // command channel
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [Data_In_Width-1:0]   cmd_A;
  logic [Data_In_Width-1:0]   cmd_B;
  logic [3:0]                 cmd_fun;
  // arithmetic unit side
  logic [Data_In_Width-1:0]   A_out;
  logic [Data_In_Width-1:0]   B_out;
  logic [3:0]                 alu_fun_out;
  logic                       arith_En_out;
  logic [2*Data_In_Width-1:0] arith_out_in;
  logic                       arith_flag_in;
  logic                       over_flow_in;
  // response channel
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [2*Data_In_Width-1:0] rsp_data;
  logic                       rsp_ovf;
  logic                       rsp_div0;
  logic                       rsp_err;
  logic [CNT_W-1:0]           ops_done;

  modport master (
    input  cmd_valid, cmd_A, cmd_B, cmd_fun,
    input  arith_out_in, arith_flag_in, over_flow_in,
    input  rsp_ready,
    output cmd_ready,
    output A_out, B_out, alu_fun_out, arith_En_out,
    output rsp_valid, rsp_data, rsp_ovf, rsp_div0, rsp_err, ops_done
  );

  modport slave (
    output cmd_valid, cmd_A, cmd_B, cmd_fun,
    output arith_out_in, arith_flag_in, over_flow_in,
    output rsp_ready,
    input  cmd_ready,
    input  A_out, B_out, alu_fun_out, arith_En_out,
    input  rsp_valid, rsp_data, rsp_ovf, rsp_div0, rsp_err, ops_done
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command-side master for the registered arithmetic unit.
// Accepts one operation at a time on a valid/ready command channel, drives
// the ALU operand/function/enable inputs, captures the registered result when
// arith_flag returns and presents it on a valid/ready response channel.
// Divides by zero are answered locally without touching the ALU; a missing
// flag after TIMEOUT wait cycles produces an error response.
// Ports:
//   CLK_in : clock, rising edge
//   RST_in : asynchronous active-low reset
//   bus    : alu_cmd_issuer_if.master (command, ALU and response signals)
// Parameters:
//   Data_In_Width : operand width, result is 2*Data_In_Width
//   TIMEOUT       : wait cycles allowed for arith_flag (>= 1)
//   CNT_W         : width of the wrapping completed-operation counter
module alu_cmd_issuer #(
  parameter int Data_In_Width = 16,
  parameter int TIMEOUT       = 4,
  parameter int CNT_W         = 8
) (
  input logic              CLK_in,
  input logic              RST_in,
  alu_cmd_issuer_if.master bus
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                     state, state_nxt;

  logic [Data_In_Width-1:0]   a_q, b_q;
  logic [3:0]                 fun_q;
  logic [2*Data_In_Width-1:0] data_q;
  logic                       ovf_q, div0_q, err_q, rsp_valid_q;
  logic [CNT_W-1:0]           ops_q;
  logic [TO_W-1:0]            to_cnt;

  logic cmd_ready, arith_en;
  logic accept, div_zero, to_expired, handoff;

  assign accept     = cmd_ready & bus.cmd_valid;
  assign div_zero   = (bus.cmd_fun[1:0] == 2'b11) && (bus.cmd_B == '0);
  assign to_expired = (to_cnt == TO_W'(TIMEOUT - 1));
  assign handoff    = rsp_valid_q & bus.rsp_ready;

  // state register
  always_ff @(posedge CLK_in or negedge RST_in) begin
    if (!RST_in) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = div_zero ? RESP : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (bus.arith_flag_in || to_expired) state_nxt = RESP;
      RESP:  if (handoff) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs; cmd_ready stays low while reset is held
  always_comb begin
    cmd_ready = 1'b0;
    arith_en  = 1'b0;
    unique case (state)
      IDLE:    cmd_ready = RST_in;
      ISSUE:   arith_en  = 1'b1;
      default: ;
    endcase
  end

  // datapath: command capture, result capture, timeout, response, counter
  always_ff @(posedge CLK_in or negedge RST_in) begin
    if (!RST_in) begin
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      ops_q       <= '0;
      to_cnt      <= '0;
    end else begin
      // Operands only change on acceptance, i.e. never while enable is high.
      if (accept) begin
        a_q    <= bus.cmd_A;
        b_q    <= bus.cmd_B;
        fun_q  <= bus.cmd_fun;
        data_q <= '0;
        ovf_q  <= 1'b0;
        div0_q <= div_zero;
        err_q  <= 1'b0;
      end

      if (state == ISSUE) to_cnt <= '0;

      if (state == WAIT) begin
        if (bus.arith_flag_in) begin
          data_q <= bus.arith_out_in;
          ovf_q  <= bus.over_flow_in & (fun_q[1:0] != 2'b11);
        end else if (to_expired) begin
          err_q  <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      // rsp_valid rises on the first edge spent in RESP, so with a one-cycle
      // ALU the response appears three edges after acceptance and the
      // captured fields are already stable when it is published.
      if (state == RESP && !rsp_valid_q) begin
        rsp_valid_q <= 1'b1;
      end else if (handoff) begin
        rsp_valid_q <= 1'b0;
        ops_q       <= ops_q + 1'b1;
      end
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.A_out        = a_q;
  assign bus.B_out        = b_q;
  assign bus.alu_fun_out  = fun_q;
  assign bus.arith_En_out = arith_en;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = data_q;
  assign bus.rsp_ovf      = ovf_q;
  assign bus.rsp_div0     = div0_q;
  assign bus.rsp_err      = err_q;
  assign bus.ops_done     = ops_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

  localparam int W  = 16;
  localparam int TO = 4;
  localparam int CW = 8;

  logic clk;
  logic rst_n;

  alu_cmd_issuer_if #(.Data_In_Width(W), .CNT_W(CW)) bus ();

  alu_cmd_issuer #(.Data_In_Width(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK_in (clk),
    .RST_in (rst_n),
    .bus    (bus)
  );

  int compared = 0;
  int failed   = 0;
  int exp_ops  = 0;
  int en_cnt   = 0;

  logic alu_alive;
  logic ovf_inj;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic from the function-code rules, plain integer math.
  function automatic logic [31:0] ref_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] f);
    int x, y, r;
    x = $signed(a);
    y = $signed(b);
    case (f[1:0])
      2'b00:   r = x + y;
      2'b01:   r = x - y;
      2'b10:   r = x * y;
      default: r = (y == 0) ? 0 : x / y;
    endcase
    return r;
  endfunction

  // Behavioural one-cycle registered ALU; alu_alive=0 suppresses the flag.
  logic [31:0] alu_out;
  logic        alu_flag, alu_ovf;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_flag <= 1'b0;
      alu_out  <= '0;
      alu_ovf  <= 1'b0;
    end else begin
      alu_flag <= bus.arith_En_out & alu_alive;
      if (bus.arith_En_out) begin
        alu_out <= ref_calc(bus.A_out, bus.B_out, bus.alu_fun_out);
        alu_ovf <= ovf_inj;
      end
    end
  end
  assign bus.arith_out_in  = alu_out;
  assign bus.arith_flag_in = alu_flag;
  assign bus.over_flow_in  = alu_ovf;

  always @(posedge clk) if (bus.arith_En_out) en_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // cmd_ready must never coincide with an enable pulse or a pending response.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_exclusive", {63'd0, bus.cmd_ready & (bus.arith_En_out | bus.rsp_valid)}, 64'd0);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, " A_out"}, bus.A_out, 0);
    chk({tag, " B_out"}, bus.B_out, 0);
    chk({tag, " alu_fun_out"}, bus.alu_fun_out, 0);
    chk({tag, " arith_En_out"}, bus.arith_En_out, 0);
    chk({tag, " rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, " rsp_data"}, bus.rsp_data, 0);
    chk({tag, " rsp_ovf"}, bus.rsp_ovf, 0);
    chk({tag, " rsp_div0"}, bus.rsp_div0, 0);
    chk({tag, " rsp_err"}, bus.rsp_err, 0);
    chk({tag, " ops_done"}, bus.ops_done, 0);
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, " cmd_ready"}, bus.cmd_ready, 1);
  endtask

  // One full transaction; e_lat < 0 leaves latency unchecked.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f, input logic inj, input int bp,
                        input logic [31:0] e_data, input logic e_ovf, input logic e_div0,
                        input logic e_err, input int e_lat, input int e_en);
    int en0, lat;
    wait_ready(tag);
    ovf_inj = inj;
    bus.cmd_A = a;
    bus.cmd_B = b;
    bus.cmd_fun = f;
    bus.cmd_valid = 1'b1;
    en0 = en_cnt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk({tag, " A_out"}, bus.A_out, a);
    chk({tag, " B_out"}, bus.B_out, b);
    chk({tag, " alu_fun_out"}, bus.alu_fun_out, f);
    chk({tag, " err_cleared"}, bus.rsp_err, 0);
    chk({tag, " cmd_ready_busy"}, bus.cmd_ready, 0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      chk({tag, " rsp_valid_timeout"}, bus.rsp_valid, 1);
    end else begin
      if (e_lat >= 0) chk({tag, " latency"}, lat, e_lat);
      for (int c = 0; c <= bp; c++) begin
        chk({tag, " rsp_data"}, bus.rsp_data, e_data);
        chk({tag, " rsp_ovf"}, bus.rsp_ovf, e_ovf);
        chk({tag, " rsp_div0"}, bus.rsp_div0, e_div0);
        chk({tag, " rsp_err"}, bus.rsp_err, e_err);
        chk({tag, " rsp_valid_held"}, bus.rsp_valid, 1);
        chk({tag, " cmd_ready_resp"}, bus.cmd_ready, 0);
        if (c < bp) begin
          @(posedge clk); #1;
        end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      exp_ops++;
    end
    chk({tag, " rsp_valid_drop"}, bus.rsp_valid, 0);
    chk({tag, " ops_done"}, bus.ops_done, exp_ops % 256);
    chk({tag, " en_pulses"}, en_cnt - en0, e_en);
    chk({tag, " cmd_ready_after"}, bus.cmd_ready, 1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic        inj;
    int          bp;
    logic [31:0] d;
    logic        ovf;
    logic        div0;
    int          lat;
    int          en;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{16'd100,   -16'sd30,  4'b0000, 1'b0, 0, 32'h0000_0046, 1'b0, 1'b0,  3, 1};
    vt[1] = '{-16'sd300, 16'd200,   4'b0010, 1'b1, 5, 32'hFFFF_15A0, 1'b1, 1'b0,  3, 1};
    vt[2] = '{16'd7,     -16'sd2,   4'b0011, 1'b1, 0, 32'hFFFF_FFFD, 1'b0, 1'b0,  3, 1};
    vt[3] = '{16'd7,     16'd0,     4'b0011, 1'b1, 1, 32'h0000_0000, 1'b0, 1'b1, -1, 0};
    vt[4] = '{16'd5,     16'd9,     4'b0001, 1'b0, 2, 32'hFFFF_FFFC, 1'b0, 1'b0,  3, 1};
    vt[5] = '{16'h8000,  16'h8000,  4'b1110, 1'b0, 0, 32'h4000_0000, 1'b0, 1'b0,  3, 1};
    vt[6] = '{16'h8000,  16'd3,     4'b0111, 1'b0, 0, 32'hFFFF_D556, 1'b0, 1'b0,  3, 1};

    rst_n = 1'b0;
    alu_alive = 1'b1;
    ovf_inj = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_A = '0;
    bus.cmd_B = '0;
    bus.cmd_fun = '0;
    bus.rsp_ready = 1'b0;

    #12;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset cmd_ready", bus.cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].f, vt[i].inj, vt[i].bp,
             vt[i].d, vt[i].ovf, vt[i].div0, 1'b0, vt[i].lat, vt[i].en);
    end

    // timeout, then a normal command must come back clean
    alu_alive = 1'b0;
    run_op("timeout", 16'd1, 16'd2, 4'b0000, 1'b1, 1, 32'h0, 1'b0, 1'b0, 1'b1, 2 + TO, 1);
    alu_alive = 1'b1;
    run_op("after_timeout", 16'd1, 16'd2, 4'b0000, 1'b0, 0, 32'h3, 1'b0, 1'b0, 1'b0, 3, 1);

    // reset while waiting for the flag
    alu_alive = 1'b0;
    wait_ready("rst_wait");
    bus.cmd_A = 16'd11;
    bus.cmd_B = 16'd22;
    bus.cmd_fun = 4'b0000;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #3;
    chk("rst_wait in_wait_en", bus.arith_En_out, 0);
    chk("rst_wait in_wait_valid", bus.rsp_valid, 0);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_wait");
    #2 rst_n = 1'b1;
    exp_ops = 0;
    alu_alive = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait cmd_ready", bus.cmd_ready, 1);
    chk("rst_wait ops_done", bus.ops_done, 0);

    // 256 randomized subtractions: counter must wrap back to zero
    for (int n = 0; n < 256; n++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      run_op($sformatf("wrap%0d", n), a, b, 4'b0001, 1'b0, $urandom_range(0, 1),
             ref_calc(a, b, 4'b0001), 1'b0, 1'b0, 1'b0, 3, 1);
    end
    chk("wrap ops_done_zero", bus.ops_done, 0);

    // randomized mix of functions, zero divisors and overflow injections
    for (int n = 0; n < 40; n++) begin
      logic [15:0] a, b;
      logic [3:0]  f;
      logic        inj, dz;
      a   = 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      f   = 4'($urandom_range(0, 15));
      inj = 1'($urandom_range(0, 1));
      dz  = (f[1:0] == 2'b11) && (b == 16'd0);
      run_op($sformatf("rand%0d", n), a, b, f, inj, $urandom_range(0, 3),
             dz ? 32'h0 : ref_calc(a, b, f), inj & (f[1:0] != 2'b11), dz, 1'b0,
             dz ? -1 : 3, dz ? 0 : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
